mealy_seq_n: RTL and testbench

- Parametrised successor to the fixed three-stage Mealy start/done sequencer.
- Chains NUM_STAGES downstream units: issues a one-cycle start pulse to each unit in order, waits for that unit's done, then starts the next unit.
- Adds a per-run skip mask, abort, status outputs and an optional per-stage watchdog.
- Sits between a controller (start/done) and a bank of worker units (start_out/done_in).

---
 rtl/mealy_seq_n.sv | 180 ++++++++++++++++++
 tb/tb_mealy_seq_n.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mealy_seq_n.sv
// Parametrised Mealy start/done sequencer: walks NUM_STAGES worker units in ascending order,
// honouring a per-run skip mask and abort. Optional per-stage watchdog: MEALY_SEQ_WATCHDOG_EN.
module mealy_seq_n #(
    parameter int NUM_STAGES = 3,
    parameter int IDX_W      = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_STAGES-1:0] skip_mask,
    input  logic [NUM_STAGES-1:0] done_in,
    output logic [NUM_STAGES-1:0] start_out,
    output logic                  busy,
    output logic [IDX_W-1:0]      stage_idx,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Lowest unskipped stage at or above lo; descending scan so the lowest match wins.
    function automatic pick_t pick_from(input logic [NUM_STAGES-1:0] mask,
                                        input logic [IDX_W:0]        lo);
        pick_t r;
        r.found = 1'b0;
        r.idx   = {IDX_W{1'b0}};
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (!mask[i] && (i >= int'(lo))) begin
                r.found = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

    function automatic logic [NUM_STAGES-1:0] onehot(input logic [IDX_W-1:0] idx);
        return NUM_STAGES'(1'b1) << idx;
    endfunction

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        stage_idx_q, stage_idx_d;
    logic [NUM_STAGES-1:0]   mask_q, mask_d;
    logic                    busy_q, busy_d;
    logic [NUM_STAGES-1:0]   start_out_s;
    logic                    done_s;
    logic                    done_hit_s;
    pick_t                   first_s;
    pick_t                   next_s;

`ifdef MEALY_SEQ_WATCHDOG_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] wdog_q, wdog_d;
    logic             limit_s;
    logic             error_q, error_d;

    assign limit_s = (wdog_q == CNT_W'(TIMEOUT - 1));
`endif

    assign first_s    = pick_from(skip_mask, {(IDX_W+1){1'b0}});
    assign next_s     = pick_from(mask_q, {1'b0, stage_idx_q} + (IDX_W+1)'(1));
    assign done_hit_s = done_in[stage_idx_q];

    // Next-state and Mealy output decode; abort outranks done_in, which outranks the watchdog.
    always_comb begin
        state_d     = state_q;
        stage_idx_d = stage_idx_q;
        mask_d      = mask_q;
        busy_d      = busy_q;
        start_out_s = {NUM_STAGES{1'b0}};
        done_s      = 1'b0;
`ifdef MEALY_SEQ_WATCHDOG_EN
        wdog_d      = wdog_q;
        error_d     = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    mask_d = skip_mask;
                    if (first_s.found) begin
                        start_out_s = onehot(first_s.idx);
                        state_d     = ST_RUN;
                        stage_idx_d = first_s.idx;
                        busy_d      = 1'b1;
`ifdef MEALY_SEQ_WATCHDOG_EN
                        wdog_d      = {CNT_W{1'b0}};
`endif
                    end else begin
                        done_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d     = ST_IDLE;
                    stage_idx_d = {IDX_W{1'b0}};
                    busy_d      = 1'b0;
                end else if (done_hit_s) begin
                    if (next_s.found) begin
                        start_out_s = onehot(next_s.idx);
                        stage_idx_d = next_s.idx;
`ifdef MEALY_SEQ_WATCHDOG_EN
                        wdog_d      = {CNT_W{1'b0}};
`endif
                    end else begin
                        done_s      = 1'b1;
                        state_d     = ST_IDLE;
                        stage_idx_d = {IDX_W{1'b0}};
                        busy_d      = 1'b0;
                    end
`ifdef MEALY_SEQ_WATCHDOG_EN
                end else if (limit_s) begin
                    state_d     = ST_IDLE;
                    stage_idx_d = {IDX_W{1'b0}};
                    busy_d      = 1'b0;
                    error_d     = 1'b1;
                end else begin
                    wdog_d = wdog_q + CNT_W'(1);
                end
`else
                end else begin
                    state_d = ST_RUN;
                end
`endif
            end
            default: begin
                state_d     = ST_IDLE;
                stage_idx_d = {IDX_W{1'b0}};
                busy_d      = 1'b0;
            end
        endcase
    end

    // State and registered-output update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            stage_idx_q <= {IDX_W{1'b0}};
            mask_q      <= {NUM_STAGES{1'b0}};
            busy_q      <= 1'b0;
`ifdef MEALY_SEQ_WATCHDOG_EN
            wdog_q      <= {CNT_W{1'b0}};
            error_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            stage_idx_q <= stage_idx_d;
            mask_q      <= mask_d;
            busy_q      <= busy_d;
`ifdef MEALY_SEQ_WATCHDOG_EN
            wdog_q      <= wdog_d;
            error_q     <= error_d;
`endif
        end
    end

    // Pulses are gated by reset so nothing leaks out while the block is held in reset.
    assign start_out = reset ? start_out_s : {NUM_STAGES{1'b0}};
    assign done      = reset & done_s;
    assign busy      = busy_q;
    assign stage_idx = stage_idx_q;

`ifdef MEALY_SEQ_WATCHDOG_EN
    assign error = reset & error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mealy_seq_n.sv
// Bench for mealy_seq_n: directed scenarios then random traffic, checked against a
// queue-of-remaining-stages reference model.
module tb_mealy_seq_n;

    localparam int N  = 3;
    localparam int TO = 4;
`ifdef MEALY_SEQ_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         abort;
    logic [N-1:0] skip_mask;
    logic [N-1:0] done_in;
    logic [N-1:0] start_out;
    logic         busy;
    logic [1:0]   stage_idx;
    logic         done;
    logic         error;

    int tests = 0;
    int fails = 0;

    // Reference model: running flag, queue of stages still to finish, cycles waited in stage.
    bit m_run  = 1'b0;
    int m_q[$];
    int m_wait = 0;
    bit m_err  = 1'b0;

    mealy_seq_n #(.NUM_STAGES(N), .IDX_W(2), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .skip_mask (skip_mask),
        .done_in   (done_in),
        .start_out (start_out),
        .busy      (busy),
        .stage_idx (stage_idx),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check outputs against the model, advance the model and clock.
    task automatic step(input logic r, input logic s, input logic a,
                        input logic [N-1:0] m, input logic [N-1:0] d);
        logic [N-1:0] e_so;
        logic         e_done;
        logic         e_err;
        logic         e_busy;
        int           e_idx;
        reset = r; start = s; abort = a; skip_mask = m; done_in = d;
        #3;
        e_so   = '0;
        e_done = 1'b0;
        e_busy = m_run;
        e_idx  = m_run ? m_q[0] : 0;
        e_err  = m_err && r;
        if (!r) begin
            m_run = 1'b0; m_q.delete(); m_wait = 0; m_err = 1'b0;
        end else begin
            m_err = 1'b0;
            if (!m_run) begin
                if (s && !a) begin
                    m_q.delete();
                    for (int i = 0; i < N; i++) if (!m[i]) m_q.push_back(i);
                    if (m_q.size() == 0) e_done = 1'b1;
                    else begin
                        e_so = N'(1) << m_q[0];
                        m_run = 1'b1; m_wait = 0;
                    end
                end
            end else if (a) begin
                m_run = 1'b0; m_q.delete();
            end else if (d[m_q[0]]) begin
                void'(m_q.pop_front());
                m_wait = 0;
                if (m_q.size() > 0) e_so = N'(1) << m_q[0];
                else begin
                    e_done = 1'b1; m_run = 1'b0;
                end
            end else begin
                m_wait++;
                if (WD && m_wait == TO) begin
                    m_run = 1'b0; m_q.delete(); m_err = 1'b1;
                end
            end
        end
        chk("start_out", 32'(start_out), 32'(e_so));
        chk("done", 32'(done), 32'(e_done));
        chk("error", 32'(error), 32'(e_err));
        if (r) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("stage_idx", 32'(stage_idx), 32'(e_idx));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic         rr, rs, ra;
        logic [N-1:0] rm, rd;
        #1;
        step(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);

        // Full run, all stages enabled, stage 0 answers after a few idle cycles.
        step(1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b001);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b010);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b100);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);

        // Skip stage 1, then skip everything.
        step(1'b1, 1'b1, 1'b0, 3'b010, 3'b000);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b001);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b010);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b100);
        step(1'b1, 1'b1, 1'b0, 3'b111, 3'b000);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);

        // Ignored done_in bits and start while running.
        step(1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b001);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b101);
        step(1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b010);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b100);

        // Abort colliding with done at stage 2, then a clean run.
        step(1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b001);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b010);
        step(1'b1, 1'b0, 1'b1, 3'b000, 3'b100);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b1, 1'b1, 1'b1, 3'b000, 3'b000);
        step(1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b001);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b010);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b100);

        // Reset mid-run at stage 1 with start held, then a stale done.
        step(1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b001);
        step(1'b0, 1'b1, 1'b0, 3'b000, 3'b000);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b010);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);

        // Watchdog expiry at stage 0, then done on the limit cycle.
        step(1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
        for (int k = 0; k < 6; k++) step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b1, 1'b0, 1'b1, 3'b000, 3'b000);
        step(1'b1, 1'b1, 1'b0, 3'b000, 3'b000);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b001);
        step(1'b1, 1'b0, 1'b1, 3'b000, 3'b000);
        step(1'b1, 1'b0, 1'b0, 3'b000, 3'b000);

        // Random traffic.
        for (int k = 0; k < 600; k++) begin
            rr = ($urandom_range(0, 49) != 0);
            rs = ($urandom_range(0, 2) == 0);
            ra = ($urandom_range(0, 19) == 0);
            rm = N'($urandom);
            rd = N'($urandom) & N'($urandom);
            step(rr, rs, ra, rm, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
